bcd_timer_ctrl: RTL and testbench
=================================

Name: bcd_timer_ctrl

Overview:
- Controller that sequences a chain of NDIGITS decade (0-9) up/down digit counters as a loadable stopwatch/countdown timer.
- Owns the run/pause/done state machine, preset validation, the up-mode limit register and single-cycle carry/borrow rippling across digits.
- Advances on an external prescaled tick strobe.
- Sits between the front-panel/button logic and the 7-segment display drivers.

Parameters:
- NDIGITS, 4, number of BCD digits in the chain. Legal range 1-8.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- tick  input  1  one-cycle count-enable strobe from the prescaler.
- mode_up  input  1  count direction: 0 = down to zero, 1 = up to limit. Sampled only on an accepted load.
- preset  input  4*NDIGITS  BCD value; digit 0 is bits [3:0].
- load  input  1  load preset (accepted only when state is not RUN).
- start  input  1  start or resume counting.
- pause  input  1  suspend counting.
- clear  input  1  abort counting and return to IDLE with count 0.
- count  output  4*NDIGITS  current BCD value, registered.
- running  output  1  high while state == RUN.
- done  output  1  one-cycle pulse when the terminal value is reached.
- err  output  1  one-cycle pulse when a load is rejected because preset contains a digit greater than 9.

Behaviour:
- Reset: state IDLE; count, limit and mode_r all 0; running, done and err all 0.
- States: IDLE, RUN, PAUSED, DONE. Every output is registered, so each effect appears the cycle after the causing edge.
- Terminal value:
  - mode_r = 0: count == 0.
  - mode_r = 1: count == limit.
- Input priority within a cycle: clear, then load, then pause, then start, then tick.
- clear (any state): state IDLE, count 0, limit 0, mode_r unchanged. No done pulse.
- load (IDLE, PAUSED or DONE):
  - If any preset digit is greater than 9: err pulses; count, limit, mode_r and state are unchanged.
  - Otherwise, mode_r = mode_up and state becomes IDLE.
  - Down mode: count = preset.
  - Up mode: limit = preset, count = 0.
  - load while in RUN: ignored, no err.
- start (IDLE or PAUSED):
  - If count is already terminal: state DONE and done pulses, with no counting.
  - Otherwise: state RUN.
  - start in RUN or DONE: ignored.
- pause in RUN: state PAUSED. A tick in the same cycle is dropped.
- tick in RUN: count steps by exactly 1 in mode_r direction.
  - Digit 0 always steps. Digit k steps only when all lower digits wrap.
  - Up step: 9 wraps to 0 with carry. Down step: 0 wraps to 9 with borrow.
  - Full ripple completes in one cycle.
  - If the new count is terminal: state DONE and done pulses in the same cycle that the new count is visible.
- tick outside RUN: ignored.
- DONE: count holds the terminal value. Only clear or load leaves DONE.
- Wrap of the whole chain cannot occur:
  - Down mode stops at 0.
  - Up mode stops at limit, and limit is at most all nines.
- Reset mid-run: the next cycle is the full reset state. No done pulse.
- Held levels:
  - start held high does not retrigger after DONE.
  - pause held high keeps the block in PAUSED; start is lower priority, so the block does not resume.

Decomposition:
- Package/header bcd_timer_pkg:
  - state encodings ST_IDLE = 0, ST_RUN = 1, ST_PAUSED = 2, ST_DONE = 3.
  - constant BCD_MAX = 4'd9.
  - function is_valid_bcd(4-bit).
- Sub-module bcd_digit, instantiated NDIGITS times in a generate loop:
  - inputs: en, up, d_in (current digit).
  - outputs: d_next, wrap (carry/borrow out).
  - purely combinational step logic; the controller holds the count register, so clear and load stay centralised.
- Controller: FSM, limit/mode_r registers, terminal compare, validation, pulse generation.

Test Plan (NDIGITS = 4):
- Down count: load preset = 0x0012, mode_up = 0, start, 12 ticks. Count runs 0012, 0011, 0010, 0009 … 0000. done pulses exactly once with count = 0000; state DONE; further ticks leave count at 0000.
- Up count with borrow/carry ripple: load preset = 0x1000, mode_up = 1 (count = 0000), start, 1000 ticks. Count passes 0099→0100 and 0999→1000 in one cycle each. done pulses with count = 1000.
- Pause/resume: running down from 0050, assert pause together with tick. Count holds 0050 and running = 0. Ticks while PAUSED do not change count. start then 3 ticks gives 0047.
- Invalid preset: in IDLE with count 0034, load preset = 0x12A4. err pulses 1 cycle; count stays 0034. load while RUN: no change and no err.
- Terminal start and clear: load down preset 0x0000, start. Next cycle done = 1 and state DONE, with no RUN cycle. Then clear: count = 0000, state IDLE; start then runs again only after a valid load.
- Mid-run reset: running up from 0000 toward limit 0020 at count 0007, assert rst for 1 cycle. Next cycle count = 0000, limit = 0, running = 0, done = 0; ticks are ignored until load and start.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared types and helpers for the BCD timer controller.
//   state_e       - controller FSM encoding
//   BCD_MAX       - largest legal decimal digit
//   is_valid_bcd  - true when a nibble holds a legal decimal digit
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_valid_bcd(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: combinational single-digit decade step.
//   en     - step this digit (all lower digits wrapped)
//   up     - 1 = increment, 0 = decrement
//   d_in   - current digit value
//   d_next - stepped digit value (d_in when en is low)
//   wrap   - carry (up, 9->0) or borrow (down, 0->9) out; only when en
module bcd_digit
    import bcd_timer_pkg::*;
(
    input  logic       en,
    input  logic       up,
    input  logic [3:0] d_in,
    output logic [3:0] d_next,
    output logic       wrap
);

    always_comb begin
        d_next = d_in;
        wrap   = 1'b0;
        if (en) begin
            if (up) begin
                if (d_in >= BCD_MAX) begin
                    d_next = 4'd0;
                    wrap   = 1'b1;
                end else begin
                    d_next = d_in + 4'd1;
                end
            end else begin
                if (d_in == 4'd0) begin
                    d_next = BCD_MAX;
                    wrap   = 1'b1;
                end else begin
                    d_next = d_in - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: loadable stopwatch / countdown timer over NDIGITS BCD digits.
//   clk, rst  - clock, synchronous active-high reset
//   tick      - prescaled count-enable strobe
//   mode_up   - direction captured on an accepted load (1 = up to limit)
//   preset    - BCD load value, digit 0 in [3:0]
//   load/start/pause/clear - front-panel commands (priority clear > load > pause > start > tick)
//   count     - registered BCD count
//   running   - state is RUN
//   done      - one-cycle pulse when the terminal value is reached
//   err       - one-cycle pulse when a load is rejected for an illegal digit
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   mode_up,
    input  logic [4*NDIGITS-1:0]   preset,
    input  logic                   load,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   clear,
    output logic [4*NDIGITS-1:0]   count,
    output logic                   running,
    output logic                   done,
    output logic                   err
);

    typedef logic [NDIGITS-1:0][3:0] bcd_t;

    state_e state_q, state_d;
    bcd_t   count_q, count_d;
    bcd_t   limit_q, limit_d;
    logic   mode_q,  mode_d;
    logic   done_q,  done_d;
    logic   err_q,   err_d;

    bcd_t               preset_bcd;
    bcd_t               count_step;
    logic [NDIGITS-1:0] dig_en;
    logic [NDIGITS-1:0] dig_wrap;
    logic               preset_ok;
    logic               term_cur;
    logic               term_step;

    assign preset_bcd = preset;

    // Ripple chain: digit k steps only when every lower digit wrapped.
    assign dig_en[0] = 1'b1;
    for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
        if (k > 0) begin : g_en
            assign dig_en[k] = dig_wrap[k-1];
        end
        bcd_digit u_digit (
            .en     (dig_en[k]),
            .up     (mode_q),
            .d_in   (count_q[k]),
            .d_next (count_step[k]),
            .wrap   (dig_wrap[k])
        );
    end

    always_comb begin
        preset_ok = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (!is_valid_bcd(preset_bcd[i])) preset_ok = 1'b0;
        end
    end

    assign term_cur  = mode_q ? (count_q == limit_q)    : (count_q == '0);
    assign term_step = mode_q ? (count_step == limit_q) : (count_step == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. A load in RUN is ignored and falls through to the
    // lower-priority commands; an asserted pause always consumes the cycle,
    // so a held pause keeps start from resuming.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            limit_d = '0;
        end else if (load && state_q != ST_RUN) begin
            if (!preset_ok) begin
                err_d = 1'b1;
            end else begin
                state_d = ST_IDLE;
                mode_d  = mode_up;
                if (mode_up) begin
                    limit_d = preset_bcd;
                    count_d = '0;
                end else begin
                    count_d = preset_bcd;
                end
            end
        end else if (pause) begin
            if (state_q == ST_RUN) state_d = ST_PAUSED;
        end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSED)) begin
            if (term_cur) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (tick && state_q == ST_RUN && !dig_wrap[NDIGITS-1]) begin
            // A whole-chain wrap is unreachable because counting stops at the
            // terminal value; the guard just keeps a corrupted count bounded.
            count_d = count_step;
            if (term_step) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        count   = count_q;
        running = (state_q == ST_RUN);
        done    = done_q;
        err     = err_q;
    end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
module tb_bcd_timer_ctrl;

    localparam int ND = 4;
    localparam int W  = 4 * ND;

    logic         clk;
    logic         rst, tick, mode_up, load, start, pause, clear;
    logic [W-1:0] preset;
    logic [W-1:0] count;
    logic         running, done, err;

    bcd_timer_ctrl #(.NDIGITS(ND)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .mode_up (mode_up),
        .preset  (preset),
        .load    (load),
        .start   (start),
        .pause   (pause),
        .clear   (clear),
        .count   (count),
        .running (running),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         run;
        logic         dn;
        logic         er;
    } exp_t;

    exp_t q[$];
    bit   mon_en = 0;
    int   errors = 0;
    int   checks = 0;

    // Reference model: count and limit kept as plain integers.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    int m_st  = M_IDLE;
    int m_cnt = 0;
    int m_lim = 0;
    bit m_up  = 0;

    function automatic int bcd2int(input logic [W-1:0] b);
        int v = 0;
        for (int i = ND - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [W-1:0] b);
        for (int i = 0; i < ND; i++) if (b[4*i +: 4] > 4'd9) return 0;
        return 1;
    endfunction

    function automatic bit m_term();
        return m_up ? (m_cnt == m_lim) : (m_cnt == 0);
    endfunction

    // One clock of stimulus: drive inputs, advance model, queue expectation.
    task automatic cyc(input bit r, input bit t, input bit s, input bit p,
                       input bit c, input bit l, input bit m, input logic [W-1:0] pre);
        exp_t e;
        bit   dn = 0, er = 0;
        @(negedge clk);
        rst = r; tick = t; start = s; pause = p; clear = c; load = l;
        mode_up = m; preset = pre;
        if (r) begin
            m_st = M_IDLE; m_cnt = 0; m_lim = 0; m_up = 0;
        end else if (c) begin
            m_st = M_IDLE; m_cnt = 0; m_lim = 0;
        end else if (l && m_st != M_RUN) begin
            if (!bcd_ok(pre)) er = 1;
            else begin
                m_st = M_IDLE;
                m_up = m;
                if (m) begin m_lim = bcd2int(pre); m_cnt = 0; end
                else m_cnt = bcd2int(pre);
            end
        end else if (p) begin
            if (m_st == M_RUN) m_st = M_PAUSED;
        end else if (s && (m_st == M_IDLE || m_st == M_PAUSED)) begin
            if (m_term()) begin m_st = M_DONE; dn = 1; end
            else m_st = M_RUN;
        end else if (t && m_st == M_RUN) begin
            m_cnt = m_up ? m_cnt + 1 : m_cnt - 1;
            if (m_term()) begin m_st = M_DONE; dn = 1; end
        end
        e.cnt = int2bcd(m_cnt);
        e.run = (m_st == M_RUN);
        e.dn  = dn;
        e.er  = er;
        q.push_back(e);
        mon_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic do_load(input logic [W-1:0] pre, input bit m);
        cyc(0, 0, 0, 0, 0, 1, m, pre);
    endtask

    task automatic do_start();
        cyc(0, 0, 1, 0, 0, 0, 0, '0);
    endtask

    task automatic do_clear();
        cyc(0, 0, 0, 0, 1, 0, 0, '0);
    endtask

    // Monitor: every cycle the DUT presents a registered output set.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard-empty @%0t: got count=%h, required a queued expectation", $time, count);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (count !== e.cnt || running !== e.run || done !== e.dn || err !== e.er) begin
                    errors++;
                    $display("FAIL outputs @%0t: got count=%h running=%b done=%b err=%b, required count=%h running=%b done=%b err=%b",
                             $time, count, running, done, err, e.cnt, e.run, e.dn, e.er);
                end
            end
        end
    end

    function automatic logic [W-1:0] rand_preset();
        if ($urandom_range(0, 9) == 0) return W'($urandom);
        return int2bcd(int'($urandom_range(0, 40)));
    endfunction

    initial begin
        rst = 1; tick = 0; mode_up = 0; preset = '0;
        load = 0; start = 0; pause = 0; clear = 0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0, '0);
        cyc(1, 1, 1, 0, 0, 0, 0, '0);
        idle(2);

        // Down count 0012 -> 0000, extra ticks hold at 0000
        do_load(16'h0012, 0);
        do_start();
        ticks(12);
        ticks(3);

        // Up count to 1000 through 0099->0100 and 0999->1000
        do_load(16'h1000, 1);
        do_start();
        ticks(1002);

        // Pause with tick, ticks while paused, held pause blocks start, resume
        do_load(16'h0050, 0);
        do_start();
        cyc(0, 1, 0, 1, 0, 0, 0, '0);
        ticks(3);
        cyc(0, 1, 1, 1, 0, 0, 0, '0);
        do_start();
        ticks(3);

        // Invalid preset in IDLE, then load while RUN
        do_clear();
        do_load(16'h0034, 0);
        do_load(16'h12A4, 0);
        do_start();
        cyc(0, 1, 0, 0, 0, 1, 1, 16'h0099);
        cyc(0, 0, 0, 0, 0, 1, 0, 16'h00F0);
        ticks(2);

        // Terminal start, held start, clear, start after clear
        do_clear();
        do_load(16'h0000, 0);
        do_start();
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0, 0, '0);
        do_clear();
        do_start();
        do_load(16'h0003, 0);
        do_start();
        ticks(4);

        // Mid-run reset
        do_load(16'h0020, 1);
        do_start();
        ticks(7);
        cyc(1, 1, 0, 0, 0, 0, 0, '0);
        ticks(3);
        do_start();
        ticks(2);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit r, c, l, p, s, t, m;
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 59) == 0);
            l = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 24) == 0);
            s = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 9) < 6);
            m = 1'($urandom_range(0, 1));
            cyc(r, t, s, p, c, l, m, rand_preset());
        end

        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard-drain: got %0d pending expectations, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
